// File: rtl/vec_itr_ctrl_if.sv
// Handshake bundle between the vectored interrupt controller and the processor.
interface vec_itr_ctrl_if #(
    parameter int N_SRC = 4,
    parameter int AW    = 8
);
    logic [N_SRC-1:0] itr_src;
    logic [N_SRC-1:0] mask_in;
    logic             mask_set;
    logic             itr_en;
    logic             itr_ack;
    logic             itr_ret;
    logic             itr_clr;

    logic             i_pending;
    logic [AW-1:0]    pc_addr;
    logic [N_SRC-1:0] itr_reg;
    logic [N_SRC-1:0] mask_reg;
    logic [2:0]       nest_lvl;
    logic             ret_err;

    // Processor / interrupt source side
    modport master (
        output itr_src, mask_in, mask_set, itr_en, itr_ack, itr_ret, itr_clr,
        input  i_pending, pc_addr, itr_reg, mask_reg, nest_lvl, ret_err
    );

    // Controller side
    modport slave (
        input  itr_src, mask_in, mask_set, itr_en, itr_ack, itr_ret, itr_clr,
        output i_pending, pc_addr, itr_reg, mask_reg, nest_lvl, ret_err
    );
endinterface

// File: rtl/vec_itr_ctrl.sv
// Vectored, nestable priority interrupt controller.
// Rising edges on itr_src latch pending bits; the lowest-index unmasked pending
// source that outranks the top in-service handler is offered to the processor
// as a vector. Acknowledged ids go onto an in-service stack of DEPTH entries.
// The bus interface must be instantiated with the same N_SRC and AW.
module vec_itr_ctrl #(
    parameter int            N_SRC      = 4,
    parameter int            AW         = 8,
    parameter logic [AW-1:0] VEC_BASE   = 8'hF0,
    parameter int            VEC_STRIDE = 2,
    parameter int            DEPTH      = 2
) (
    input  logic           g_clk,
    input  logic           g_clr,
    vec_itr_ctrl_if.slave  bus
);
    localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t           state, state_nxt;
    logic [N_SRC-1:0] src_q, pend, pend_nxt, mask, elig, rise, ack_clr;
    logic [IDW-1:0]   lat_id, lat_nxt, win_id, top_id;
    logic             win_vld, withdraw, do_pop, do_push;
    logic [AW-1:0]    pc_q, pc_nxt;
    logic [2:0]       nest, nest_pop, nest_nxt;
    logic             err_q, err_nxt;
    logic [IDW-1:0]   stk [DEPTH];

    // Edge detect, eligibility and priority pick against the top in-service id
    always_comb begin
        rise   = bus.itr_src & ~src_q;
        elig   = pend & ~mask;
        top_id = '0;
        for (int i = 0; i < DEPTH; i++)
            if (3'(i) == nest - 3'd1) top_id = stk[i];
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i] && (nest == 3'd0 || IDW'(i) < top_id)) begin
                win_vld = 1'b1;
                win_id  = IDW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, stack control and vector latch
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_id;
        pc_nxt    = pc_q;
        err_nxt   = err_q;
        do_pop    = 1'b0;
        do_push   = 1'b0;
        ack_clr   = '0;
        withdraw  = !bus.itr_en || bus.itr_clr || (bus.mask_set && bus.mask_in[lat_id]);

        // A return pops in any state; with nothing in service it only flags an error
        if (bus.itr_ret) begin
            if (nest == 3'd0) err_nxt = 1'b1;
            else              do_pop  = 1'b1;
        end
        nest_pop = do_pop ? nest - 3'd1 : nest;
        nest_nxt = nest_pop;

        case (state)
            REQ: begin
                if (bus.itr_ack) begin
                    // Pop (if any) happens first, so the push lands on the popped slot
                    do_push  = 1'b1;
                    nest_nxt = nest_pop + 3'd1;
                    for (int i = 0; i < N_SRC; i++)
                        if (IDW'(i) == lat_id) ack_clr[i] = 1'b1;
                    state_nxt = SERV;
                end else if (withdraw) begin
                    state_nxt = (nest_pop == 3'd0) ? IDLE : SERV;
                end
            end
            default: begin
                if (state == SERV && do_pop) begin
                    state_nxt = (nest_pop == 3'd0) ? IDLE : SERV;
                end else if (win_vld && bus.itr_en && int'(nest) < DEPTH) begin
                    state_nxt = REQ;
                    lat_nxt   = win_id;
                    pc_nxt    = VEC_BASE + AW'(win_id) * AW'(VEC_STRIDE);
                end
            end
        endcase

        // Clear beats both acknowledge and a simultaneous new edge
        pend_nxt = bus.itr_clr ? '0 : ((pend & ~ack_clr) | rise);
    end

    // Datapath registers; src_q resets high so levels held at release are not edges
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            src_q  <= '1;
            pend   <= '0;
            mask   <= '1;
            nest   <= '0;
            err_q  <= 1'b0;
            lat_id <= '0;
            pc_q   <= '0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else begin
            src_q  <= bus.itr_src;
            pend   <= pend_nxt;
            if (bus.mask_set) mask <= bus.mask_in;
            nest   <= nest_nxt;
            err_q  <= err_nxt;
            lat_id <= lat_nxt;
            pc_q   <= pc_nxt;
            for (int i = 0; i < DEPTH; i++)
                if (do_push && 3'(i) == nest_pop) stk[i] <= lat_id;
        end
    end

    assign bus.i_pending = (state == REQ);
    assign bus.pc_addr   = pc_q;
    assign bus.itr_reg   = pend;
    assign bus.mask_reg  = mask;
    assign bus.nest_lvl  = nest;
    assign bus.ret_err   = err_q;
endmodule

// File: doc/vec_itr_ctrl.md
VEC_ITR_CTRL -- requirements
Module: vec_itr_ctrl

Interface
REQ-001 Parameter N_SRC, default 4: number of interrupt sources, legal range 2..8.
REQ-002 Parameter AW, default 8: vector address width, equal to the PC width.
REQ-003 Parameter VEC_BASE, default 8'hF0: address of the source 0 handler.
REQ-004 Parameter VEC_STRIDE, default 2: address spacing between handler entries.
REQ-005 Parameter DEPTH, default 2: maximum interrupt nesting depth, legal range 1..4.
REQ-006 Port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port g_clr, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port itr_src, input, N_SRC bits: level interrupt request lines; bit 0 has the highest priority.
REQ-009 Port mask_in, input, N_SRC bits: new mask value; a 1 blocks that source.
REQ-010 Port mask_set, input, 1 bit: loads mask_in into the mask register.
REQ-011 Port itr_en, input, 1 bit: global interrupt enable.
REQ-012 Port itr_ack, input, 1 bit: processor has taken the vector.
REQ-013 Port itr_ret, input, 1 bit: return from the current handler.
REQ-014 Port itr_clr, input, 1 bit: synchronous clear of all pending bits.
REQ-015 Port i_pending, output, 1 bit: interrupt request to the processor.
REQ-016 Port pc_addr, output, AW bits: handler vector.
REQ-017 Port itr_reg, output, N_SRC bits: pending register.
REQ-018 Port mask_reg, output, N_SRC bits: mask register.
REQ-019 Port nest_lvl, output, 3 bits: number of in-service entries.
REQ-020 Port ret_err, output, 1 bit: sticky error, set by a return with nothing in service.

Function
REQ-021 Each pending bit SHALL set on a 0->1 edge of its itr_src bit, detected against a registered copy of itr_src.
- A pending bit stays set until acknowledged or cleared, independent of the mask.
REQ-022 Eligible set = pending & ~mask.
- The winner is the lowest-index eligible source.
- The winner must also have an index strictly lower than the top in-service id, if any is in service.
REQ-023 The FSM SHALL have exactly three states: IDLE, REQ, SERV.
REQ-024 IDLE/SERV -> REQ on the cycle after an eligible winner exists, provided itr_en=1 and nest_lvl<DEPTH.
- On that transition, the winner id and pc_addr = VEC_BASE + id*VEC_STRIDE (truncated to AW bits) are latched.
REQ-025 In REQ, i_pending=1, and pc_addr and the latched id SHALL stay stable until itr_ack.
- A higher-priority edge arriving in REQ only sets its pending bit.
REQ-026 itr_ack in REQ: clear the pending bit of the latched id, push the id onto the in-service stack, increment nest_lvl, go to SERV.
- i_pending=0 from the next cycle.
REQ-027 itr_ack outside REQ SHALL be ignored.
REQ-028 itr_ret in SERV: pop the stack and decrement nest_lvl.
- If nest_lvl becomes 0, go to IDLE; otherwise stay in SERV, with priority compared against the new top.
REQ-029 itr_ret with nest_lvl=0 SHALL leave the state unchanged and set ret_err.
REQ-030 itr_ret in REQ SHALL pop the stack.
- If nest_lvl was 0: set ret_err.
- The REQ state and the latched vector are unaffected.
REQ-031 itr_ack and itr_ret in the same REQ cycle: pop first, then push; nest_lvl is unchanged.
REQ-032 itr_en 0 in REQ SHALL return to IDLE (if nest_lvl=0) or SERV, with i_pending=0 next cycle; pending bits are retained.
REQ-033 mask_set in REQ masking the latched id: the request SHALL be withdrawn as in REQ-032.
REQ-034 itr_clr clears all pending bits.
- In REQ it withdraws the request as in REQ-032.
- Simultaneous with a new edge, the clear wins.
- The in-service stack is untouched.
REQ-035 With nest_lvl=DEPTH, no new request SHALL be raised; pending bits still accumulate.

Reset
REQ-036 g_clr=0 SHALL asynchronously set the following and hold them while low:
- state IDLE, i_pending 0, pc_addr 0, itr_reg 0;
- mask_reg all ones (all sources masked);
- nest_lvl 0, in-service stack empty, ret_err 0;
- the registered copy of itr_src set to all ones, so levels already high at release do not register as edges.
REQ-037 Reset mid-handshake SHALL discard the latched vector; the first request after release needs a new edge.

Verification
REQ-038 Single interrupt:
- Stimulus: mask=4'b0000, itr_en=1, itr_src[2] rises.
- Response: i_pending=1 with pc_addr=8'hF4 within 2 cycles.
- After ack: itr_reg[2]=0, nest_lvl=1.
- After ret: IDLE.
REQ-039 Simultaneous sources:
- Stimulus: itr_src 4'b1010 rises in one cycle.
- Response: vector 8'hF2 first; after ack, no preemption (source 3 has lower priority than 1).
- After ret: vector 8'hF6.
REQ-040 Nesting:
- Stimulus: source 3 in service, then source 0 rises.
- Response: pc_addr=8'hF0, nest_lvl=2 after ack.
- Then source 1 rises: no request (nest_lvl=DEPTH) until ret.
REQ-041 Masking:
- Stimulus: source 1 pending, mask_in=4'b0010 with mask_set in REQ.
- Response: i_pending=0 next cycle, itr_reg[1] stays 1.
- Unmask: the request is re-raised.
REQ-042 Errors and collisions:
- Stimulus: itr_ret in IDLE. Response: ret_err=1, state IDLE.
- Stimulus: ack+ret together in REQ with nest_lvl=1. Response: nest_lvl stays 1.
REQ-043 Asynchronous reset:
- Stimulus: g_clr pulsed low between clock edges while in REQ.
- Response: immediately i_pending=0, mask_reg=4'b1111, nest_lvl=0.
- After release: a held-high source raises no request.
